// File: rtl/acq_sched_pkg.sv
// Shared types and helpers for the acquisition-engine scheduler.
package acq_sched_pkg;

  // Scheduler FSM states; the encoding is visible on DBG_STATE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_SETUP = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Width of the saturating error counter.
  localparam int ERR_CNT_W = 8;

  // Largest requester count supported by the round-robin picker.
  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  // Result of one round-robin pick.
  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr (modulo n) whose request bit is set.
  // Offsets are scanned from the far end down so the smallest offset wins.
  function automatic rr_pick_t rr_pick_fn(input logic [RR_MAX-1:0]   req,
                                          input logic [RR_IDX_W-1:0] ptr,
                                          input int                  n);
    rr_pick_t            res;
    logic [RR_IDX_W-1:0] kk;
    res = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        kk = RR_IDX_W'((int'(ptr) + i) % n);
        if (req[kk]) begin
          res.valid = 1'b1;
          res.idx   = kk;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/acq_sched_rr_pick.sv
// Combinational rotating-priority picker, reusable by any shared-resource arbiter.
module rr_pick
  import acq_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     i_req,
  input  logic [RR_IDX_W-1:0] i_ptr,
  output logic [RR_IDX_W-1:0] o_idx,
  output logic                o_valid
);

  logic [RR_MAX-1:0] w_req;
  rr_pick_t          w_pick;

  // Widen the request vector to the helper's fixed width and pick.
  always_comb begin
    w_req               = '0;
    w_req[NREQ-1:0]     = i_req;
    w_pick              = rr_pick_fn(w_req, i_ptr, NREQ);
  end

  assign o_idx   = w_pick.idx;
  assign o_valid = w_pick.valid;

endmodule

// File: rtl/acq_sched.sv
// Round-robin scheduler sharing one start/DONE counter engine among NREQ requesters.
//
// Handshakes:
//   Requester side: REQ is a level request. A one-hot GNT is raised in ARB and
//   held through SETUP/START/RUN; it drops on GAP entry. Every granted burst
//   ends with exactly one 1-cycle ACK to the granted requester (normal end,
//   timeout or zero length). REQ may drop while granted; the burst still
//   completes. REQ_DLEN is sampled once, in ARB.
//   Engine side: ENG_DLEN is stable SETUP_CYC cycles before ENG_START rises.
//   ENG_START is a level held in START until ENG_DONE is seen low, then
//   dropped. The burst is complete when ENG_DONE is seen high again in RUN.
//   ENG_START stays low for GAP_CYC cycles before the next burst.
module acq_sched
  import acq_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int SETUP_CYC = 3,
  parameter int GAP_CYC   = 4,
  parameter int TMO_CYC   = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*DW-1:0]   REQ_DLEN,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      ACK,
  output logic                 ENG_START,
  output logic [DW-1:0]        ENG_DLEN,
  input  logic                 ENG_DONE,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [2:0]           DBG_STATE
);

  // One shared cycle counter covers the SETUP, START-timeout and GAP phases.
  localparam int CMAX_SG = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CMAX    = (CMAX_SG > TMO_CYC) ? CMAX_SG : TMO_CYC;
  localparam int CW      = $clog2(CMAX + 1);

  state_t                r_state;
  state_t                w_next;
  logic [RR_IDX_W-1:0]   r_sel;
  logic [RR_IDX_W-1:0]   r_ptr;
  logic [RR_IDX_W-1:0]   w_pick_idx;
  logic                  w_pick_valid;
  logic [DW-1:0]         r_dlen;
  logic [DW-1:0]         w_sel_len;
  logic [NREQ-1:0]       w_sel_oh;
  logic [NREQ-1:0]       r_ack;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [CW-1:0]         r_cnt;
  logic                  w_cnt_run;
  logic                  w_ack_set;
  logic                  w_err_set;
  logic                  w_gnt_on;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_sel_len = REQ_DLEN[int'(r_sel) * DW +: DW];
  assign w_sel_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_sel;
  assign w_cnt_run = (r_state == S_SETUP) || (r_state == S_START) || (r_state == S_GAP);
  assign w_gnt_on  = (r_state == S_ARB) || (r_state == S_SETUP) ||
                     (r_state == S_START) || (r_state == S_RUN);

  // State register; reset returns to IDLE at once, which also drops ENG_START.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the end-of-burst ACK/ERR decisions.
  always_comb begin
    w_next    = r_state;
    w_ack_set = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_next = S_ARB;
        end
      end
      S_ARB: begin
        if (w_sel_len == '0) begin
          // Nothing to acquire: complete immediately with an error, no start.
          w_ack_set = 1'b1;
          w_err_set = 1'b1;
          w_next    = S_GAP;
        end else begin
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == CW'(SETUP_CYC - 1)) begin
          w_next = S_START;
        end
      end
      S_START: begin
        if (!ENG_DONE) begin
          w_next = S_RUN;
        end else if (r_cnt == CW'(TMO_CYC - 1)) begin
          // Engine never acknowledged the start: abandon the burst.
          w_ack_set = 1'b1;
          w_err_set = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_RUN: begin
        // Burst length is unbounded, so no timeout here.
        if (ENG_DONE) begin
          w_ack_set = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Phase counter: cleared on every state change, counts only in timed phases.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Selection, length latch and round-robin pointer advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sel  <= '0;
      r_ptr  <= '0;
      r_dlen <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_pick_valid) begin
        r_sel <= w_pick_idx;
      end
      if (r_state == S_ARB) begin
        r_dlen <= w_sel_len;
      end
      if ((w_next == S_GAP) && (r_state != S_GAP)) begin
        r_ptr <= (r_sel == RR_IDX_W'(NREQ - 1)) ? '0 : r_sel + 1'b1;
      end
    end
  end

  // Completion/error pulses and the saturating error count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ack <= w_ack_set ? w_sel_oh : '0;
      r_err <= w_err_set;
      if (w_err_set && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign GNT       = w_gnt_on ? w_sel_oh : '0;
  assign ACK       = r_ack;
  assign ENG_START = (r_state == S_START);
  assign ENG_DLEN  = r_dlen;
  assign BUSY      = (r_state != S_IDLE);
  assign ERR       = r_err;
  assign ERR_CNT   = r_err_cnt;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_acq_sched.sv
// Directed self-checking bench for acq_sched with a simple DONE-handshake engine model.
module tb_acq_sched;
  import acq_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_dlen;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 eng_start;
  logic [DW-1:0]        eng_dlen;
  logic                 eng_done;
  logic                 busy;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [2:0]           dbg_state;

  logic eng_stuck;
  int   eng_cnt;
  int   total;
  int   bad;

  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] ack_q[$];
  logic [DW-1:0]   dlen_q[$];

  acq_sched #(
    .NREQ      (NREQ),
    .DW        (DW),
    .SETUP_CYC (3),
    .GAP_CYC   (4),
    .TMO_CYC   (64)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .REQ_DLEN  (req_dlen),
    .GNT       (gnt),
    .ACK       (ack),
    .ENG_START (eng_start),
    .ENG_DLEN  (eng_dlen),
    .ENG_DONE  (eng_done),
    .BUSY      (busy),
    .ERR       (err),
    .ERR_CNT   (err_cnt),
    .DBG_STATE (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model: DONE falls 4 cycles after START is seen, rises 20 cycles later.
  initial begin
    eng_done = 1'b1;
    eng_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || eng_stuck) begin
        eng_done = 1'b1;
        eng_cnt  = 0;
      end else if (eng_done) begin
        if (eng_start) begin
          eng_cnt++;
          if (eng_cnt == 4) begin
            eng_done = 1'b0;
            eng_cnt  = 0;
          end
        end else begin
          eng_cnt = 0;
        end
      end else begin
        eng_cnt++;
        if (eng_cnt == 20) begin
          eng_done = 1'b1;
          eng_cnt  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (ack !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (dbg_state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", eng_start); end
    total++; if (eng_dlen !== 32'd0) begin bad++; $display("FAIL reset_dlen got=%0d exp=0", eng_dlen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
    rst = 1'b0;
    tick();
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] prev_gnt;
    logic            prev_start;
    logic [NREQ-1:0] e;
    logic [DW-1:0]   ed;
    int              low_run;
    int              ngnt;
    int              nstart;
    int              nack;
    int              c;
    for (int i = 0; i < NREQ; i++) req_dlen[i*DW +: DW] = DW'(i + 1);
    exp_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ack_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dlen_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
    prev_gnt = '0; prev_start = 1'b0; low_run = 0;
    ngnt = 0; nstart = 0; nack = 0; c = 0;
    req = 4'b1111;
    while ((nack < 5 || busy) && c < 500) begin
      tick();
      c++;
      if (gnt !== '0 && prev_gnt === '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rr_extra_grant got=%b exp=none", gnt);
        end else begin
          e = exp_q.pop_front();
          if (gnt !== e) begin bad++; $display("FAIL rr_grant got=%b exp=%b", gnt, e); end
        end
        ngnt++;
        if (ngnt == 5) req = '0;
      end
      if (eng_start === 1'b1 && prev_start === 1'b0) begin
        total++;
        if (dlen_q.size() == 0) begin
          bad++; $display("FAIL rr_extra_start got=%0d exp=none", eng_dlen);
        end else begin
          ed = dlen_q.pop_front();
          if (eng_dlen !== ed) begin bad++; $display("FAIL rr_dlen got=%0d exp=%0d", eng_dlen, ed); end
        end
        if (nstart > 0) begin
          total++;
          if (low_run < 4) begin bad++; $display("FAIL rr_start_gap got=%0d exp>=4", low_run); end
        end
        nstart++;
      end
      if (eng_start === 1'b1) low_run = 0; else low_run++;
      if (ack !== '0) begin
        total++;
        if (ack_q.size() == 0) begin
          bad++; $display("FAIL rr_extra_ack got=%b exp=none", ack);
        end else begin
          e = ack_q.pop_front();
          if (ack !== e) begin bad++; $display("FAIL rr_ack got=%b exp=%b", ack, e); end
        end
        nack++;
      end
      prev_gnt   = gnt;
      prev_start = eng_start;
    end
    total++; if (nack != 5 || busy !== 1'b0) begin bad++; $display("FAIL rr_complete got=%0d exp=5", nack); end
  endtask

  task automatic test_single();
    req_dlen[0 +: DW] = 32'd10;
    req = 4'b0001;
    tick();                                   // edge0: IDLE -> ARB
    req = '0;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();                                   // edge1: length latched
    total++; if (eng_dlen !== 32'd10) begin bad++; $display("FAIL single_dlen got=%0d exp=10", eng_dlen); end
    req_dlen[0 +: DW] = 32'd99;               // must be ignored from here on
    repeat (2) tick();                        // edge3
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_start_early got=%b exp=0", eng_start); end
    tick();                                   // edge4: fifth cycle
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", eng_start); end
    total++; if (eng_dlen !== 32'd10) begin bad++; $display("FAIL single_dlen_hold got=%0d exp=10", eng_dlen); end
    repeat (3) tick();                        // edge7: DONE still high at edge7
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL single_start_hold got=%b exp=1", eng_start); end
    tick();                                   // edge8: DONE low seen, RUN
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_start_drop got=%b exp=0", eng_start); end
    repeat (19) tick();                       // edge27
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_ack_early got=%b exp=0000", ack); end
    tick();                                   // edge28: DONE high seen
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b exp=0001", ack); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_gap got=%b exp=0000", gnt); end
    tick();                                   // edge29
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_ack_width got=%b exp=0000", ack); end
    repeat (2) tick();                        // edge31: last GAP cycle
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy got=%b exp=1", busy); end
    tick();                                   // edge32: IDLE
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    req_dlen[0 +: DW] = 32'd1;
  endtask

  task automatic test_zero_len();
    int hi;
    hi = 0;
    req_dlen[2*DW +: DW] = 32'd0;
    req = 4'b0100;
    tick();                                   // ARB
    req = '0;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL zero_gnt got=%b exp=0100", gnt); end
    tick();                                   // GAP entry
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL zero_ack got=%b exp=0100", ack); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL zero_err got=%b exp=1", err); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL zero_errcnt got=%0d exp=1", err_cnt); end
    for (int i = 0; i < 10; i++) begin
      if (eng_start !== 1'b0) hi++;
      tick();
    end
    total++; if (hi != 0) begin bad++; $display("FAIL zero_start got=%0d exp=0", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%b exp=0", busy); end
    req_dlen[2*DW +: DW] = 32'd3;
  endtask

  task automatic test_timeout();
    int hi;
    bit ok;
    hi = 0; ok = 1'b0;
    eng_stuck = 1'b1;
    req_dlen[0 +: DW] = 32'd5;
    req = 4'b0001;
    for (int n = 0; n < 200; n++) begin
      tick();
      req = '0;
      if (eng_start === 1'b1) hi++;
      if (ack !== '0) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL tmo_wait got=0 exp=1"); end
    total++; if (hi != 64) begin bad++; $display("FAIL tmo_start_len got=%0d exp=64", hi); end
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL tmo_ack got=%b exp=0001", ack); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", err); end
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL tmo_errcnt got=%0d exp=2", err_cnt); end
    wait_idle(ok);
    eng_stuck = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL tmo_idle got=0 exp=1"); end
    // Following request must run a normal burst.
    req_dlen[3*DW +: DW] = 32'd9;
    req = 4'b1000;
    tick();
    req = '0;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL tmo_next_gnt got=%b exp=1000", gnt); end
    wait_ack(ok);
    total++; if (ack !== 4'b1000) begin bad++; $display("FAIL tmo_next_ack got=%b exp=1000", ack); end
    total++; if (err !== 1'b0 || err_cnt !== 8'd2) begin bad++; $display("FAIL tmo_next_err got=%b/%0d exp=0/2", err, err_cnt); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_next_idle got=0 exp=1"); end
  endtask

  task automatic test_req_drop();
    bit ok;
    req_dlen[1*DW +: DW] = 32'd6;
    req_dlen[2*DW +: DW] = 32'd7;
    req = 4'b0010;
    wait_state(S_RUN, ok);
    total++; if (!ok || gnt !== 4'b0010) begin bad++; $display("FAIL drop_run got=%b exp=0010", gnt); end
    req = 4'b0100;                            // requester 1 gives up, 2 asks
    wait_ack(ok);
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL drop_ack got=%b exp=0010", ack); end
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (gnt !== '0) begin ok = 1'b1; break; end
    end
    total++; if (!ok || gnt !== 4'b0100) begin bad++; $display("FAIL drop_next_gnt got=%b exp=0100", gnt); end
    tick();
    total++; if (eng_dlen !== 32'd7) begin bad++; $display("FAIL drop_next_dlen got=%0d exp=7", eng_dlen); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nack;
    wait_state(S_RUN, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_reach_run got=%0d exp=%0d", dbg_state, S_RUN); end
    #2;
    rst = 1'b1;
    #1;                                       // no clock edge since reset rose
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", eng_start); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_errcnt got=%0d exp=0", err_cnt); end
    req = '0;
    repeat (2) tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    req = '0;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rst_regrant got=%b exp=1000", gnt); end
    wait_ack(ok);
    total++; if (ack !== 4'b1000) begin bad++; $display("FAIL rst_reack got=%b exp=1000", ack); end
    wait_idle(ok);
    // Reset while ENG_START is high must drop it without a clock edge.
    req = 4'b0001;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      req = '0;
      if (eng_start === 1'b1) begin ok = 1'b1; break; end
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (!ok || eng_start !== 1'b0) begin bad++; $display("FAIL rst_start_async got=%b exp=0", eng_start); end
    tick();
    rst = 1'b0;
    nack = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ack !== '0) nack++;
    end
    total++; if (nack != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_no_ack got=%0d exp=0", nack); end
  endtask

  task automatic test_err_sat();
    int  npulse;
    bit  ok;
    npulse = 0;
    req_dlen[0 +: DW] = 32'd0;
    req = 4'b0001;
    for (int n = 0; n < 2000 && npulse < 256; n++) begin
      tick();
      if (err === 1'b1) begin
        npulse++;
        if (npulse == 255) begin
          total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d exp=255", err_cnt); end
        end
      end
    end
    req = '0;
    total++; if (npulse != 256 || err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255 pulses=%0d", err_cnt, npulse); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_idle got=0 exp=1"); end
  endtask

  // Test sequence
  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req       = '0;
    req_dlen  = '0;
    eng_stuck = 1'b0;
    test_reset();
    test_back_to_back();
    test_single();
    test_zero_len();
    test_timeout();
    test_req_drop();
    test_reset_mid();
    test_err_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_sched.md
Name: acq_sched

Overview:
- Round-robin scheduler that shares one acquisition counter engine among NREQ requesters.
- The engine is a start/FIFO_VALID/DONE counter with a 2-stage start synchroniser and a double-registered length input.
- Per granted burst, acq_sched presents the requester's length, sequences the engine's level start, tracks its DONE handshake and returns a completion pulse.
- Sits between the host/control requesters and the counter engine, in the same CLK domain as the engine.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 32, length width
- SETUP_CYC, 3, cycles ENG_DLEN is held stable before ENG_START rises (must be ≥3)
- GAP_CYC, 4, cycles ENG_START is held low after a burst before the next start (must be ≥3)
- TMO_CYC, 64, max cycles to wait for ENG_DONE to fall after ENG_START rises

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- REQ  in  NREQ  level request per requester
- REQ_DLEN  in  NREQ*DW  packed lengths; requester i at [i*DW +: DW]
- GNT  out  NREQ  one-hot grant, held for the whole burst
- ACK  out  NREQ  1-cycle completion pulse to the granted requester
- ENG_START  out  1  level start to the engine
- ENG_DLEN  out  DW  length to the engine
- ENG_DONE  in  1  engine DONE (high when idle)
- BUSY  out  1  high in any state except IDLE
- ERR  out  1  1-cycle pulse on timeout or zero-length request
- ERR_CNT  out  8  saturating error count; cleared only by RST

Behaviour:
- Reset values: GNT=0, ACK=0, ENG_START=0, ENG_DLEN=0, BUSY=0, ERR=0, ERR_CNT=0, rr pointer=0, state=IDLE. Reset mid-burst drops ENG_START immediately; no ACK is issued.
- IDLE: if any REQ is high, pick the first requester at or after the rr pointer (modulo NREQ), go to ARB. Selection is made in IDLE and registered in ARB.
- ARB (1 cycle):
  - GNT = one-hot(sel); ENG_DLEN latched from REQ_DLEN[sel].
  - If that length is 0: ACK[sel] and ERR pulse, ERR_CNT+1, go to GAP; ENG_START is never raised.
  - Otherwise go to SETUP.
- SETUP: count SETUP_CYC cycles, then go to START.
- START: ENG_START=1 and the timeout counter starts.
  - ENG_DONE==0 seen → go to RUN.
  - Timeout counter reaches TMO_CYC with ENG_DONE still 1 → ENG_START=0, ERR pulse, ERR_CNT+1, ACK[sel] pulse, go to GAP.
- RUN:
  - ENG_START is held at 1 until ENG_DONE falls, then dropped on the following cycle (RUN entry).
  - Wait for ENG_DONE==1. On the cycle that value is sampled: ACK[sel] pulses for one cycle and the state goes to GAP.
  - No timeout applies in RUN, because burst length is unbounded.
- GAP:
  - GNT=0, ENG_START=0.
  - Count GAP_CYC cycles. The rr pointer becomes sel+1 mod NREQ on GAP entry. Then go to IDLE.
- Latency: REQ rising in IDLE → ENG_START high after 1 (IDLE) + 1 (ARB) + SETUP_CYC cycles = 5 cycles with defaults.
- REQ deassert while granted: ignored; the burst completes and ACK is still issued.
- REQ_DLEN changing after ARB: ignored (latched value is used).
- Simultaneous REQ: strict round robin; no requester is served twice while another is pending.
- ERR_CNT saturates at 255.
- ACK and ERR may pulse in the same cycle (zero length, timeout).

Decomposition:
- Package acq_sched_pkg holds:
  - state enum (IDLE, ARB, SETUP, START, RUN, GAP);
  - ERR_CNT width constant;
  - round-robin pick function (request vector, pointer → index and valid).
- One sub-module, rr_pick: combinational priority rotate, parameterised by NREQ. Kept separate so it can be reused by other shared-resource arbiters.

Test Plan:
- Single request, REQ[0]=1, DLEN=10, engine model drops DONE 4 cycles after START and raises it 20 cycles later:
  - GNT=0001, ENG_DLEN=10, ENG_START high at cycle 5;
  - one ACK[0] pulse when DONE rises; BUSY low again after GAP.
- REQ=1111 held, each DLEN=i+1:
  - grant order 0,1,2,3,0;
  - ENG_DLEN values 1,2,3,4,1;
  - ENG_START low for ≥4 cycles between bursts.
- Zero length, REQ[2]=1 with DLEN=0:
  - ACK[2] and ERR pulse together;
  - ENG_START never asserts; ERR_CNT=1.
- Timeout, engine model holds DONE=1:
  - ENG_START drops after 64 cycles; ERR and ACK pulse; ERR_CNT increments.
  - The next request is served normally.
- Requester drops REQ[1] during RUN: burst completes, ACK[1] still pulses, next grant goes to 2 if requested.
- RST asserted in RUN:
  - ENG_START, GNT and BUSY go to 0 asynchronously; ERR_CNT=0.
  - After release, REQ[3] alone is granted.
